// File: rtl/tick_timer.sv
// Loadable countdown timer driven by single-cycle tick pulses.
// Emits a one-cycle done pulse on expiry; supports pause, abort and restart.
module tick_timer #(
  parameter int N_BIT = 16
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [N_BIT-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [N_BIT-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  state_t state;

  localparam logic [N_BIT-1:0] ZERO = '0;
  localparam logic [N_BIT-1:0] ONE  = N_BIT'(1);

  always_ff @(posedge clkin) begin
    if (rst) begin
      state  <= IDLE;
      count  <= ZERO;
      busy   <= 1'b0;
      paused <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A zero load expires immediately without ever becoming busy.
          if (!abort && start) begin
            if (load_val != ZERO) begin
              count <= load_val;
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              count <= ZERO;
              done  <= 1'b1;
            end
          end
        end

        RUN, PAUSED: begin
          if (abort) begin
            state  <= IDLE;
            count  <= ZERO;
            busy   <= 1'b0;
            paused <= 1'b0;
          end else if (start) begin
            paused <= 1'b0;
            if (load_val != ZERO) begin
              count <= load_val;
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              count <= ZERO;
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (state == PAUSED) begin
            // Releasing pause consumes the edge; a coincident tick is dropped.
            if (!pause) begin
              state  <= RUN;
              paused <= 1'b0;
            end
          end else if (pause) begin
            state  <= PAUSED;
            paused <= 1'b1;
          end else if (tick) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              count <= ZERO;
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          count  <= ZERO;
          busy   <= 1'b0;
          paused <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: a cycle-level reference model pushes
// expected outputs into a scoreboard queue that is drained after each edge.
module tb_tick_timer;

  localparam int N_BIT = 16;

  logic             clkin = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             start = 1'b0;
  logic [N_BIT-1:0] load_val = '0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [N_BIT-1:0] count;
  logic             busy;
  logic             paused;
  logic             done;

  tick_timer #(.N_BIT(N_BIT)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .paused   (paused),
    .done     (done)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [N_BIT-1:0] c;
    logic             b;
    logic             p;
    logic             d;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  // Reference model state: 0 idle, 1 counting, 2 held.
  int               m_st = 0;
  logic [N_BIT-1:0] m_cnt = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic reload(input logic [N_BIT-1:0] lv, output logic m_done);
    m_done = 1'b0;
    if (lv == 0) begin
      m_cnt  = '0;
      m_st   = 0;
      m_done = 1'b1;
    end else begin
      m_cnt = lv;
      m_st  = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic t, input logic s, input logic p,
                       input logic a, input logic [N_BIT-1:0] lv);
    exp_t e;
    exp_t got_e;
    logic m_done;
    rst = r; tick = t; start = s; pause = p; abort = a; load_val = lv;
    m_done = 1'b0;
    if (r) begin
      m_st = 0; m_cnt = '0;
    end else if (m_st == 0) begin
      if (!a && s) reload(lv, m_done);
    end else if (a) begin
      m_st = 0; m_cnt = '0;
    end else if (s) begin
      reload(lv, m_done);
    end else if (m_st == 2) begin
      if (!p) m_st = 1;
    end else if (p) begin
      m_st = 2;
    end else if (t) begin
      if (m_cnt == 1) begin
        m_cnt = '0; m_st = 0; m_done = 1'b1;
      end else begin
        m_cnt = m_cnt - 1'b1;
      end
    end
    e.c = m_cnt;
    e.b = (m_st != 0);
    e.p = (m_st == 2);
    e.d = m_done;
    q.push_back(e);
    @(posedge clkin);
    #1;
    got_e = q.pop_front();
    check_val("outputs", {13'd0, count, busy, paused, done}, {13'd0, got_e});
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0);
  endtask

  task automatic ticks_n(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, '0);
  endtask

  initial begin
    int d0;
    int b0;
    int nt;

    // Reset then a run interrupted by a two-cycle reset.
    cycle(1, 0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, 0, '0);
    check_val("reset_count", {16'd0, count}, 32'd0);
    check_val("reset_flags", {29'd0, busy, paused, done}, 32'd0);
    $display("txn reset_mid_run load=7");
    cycle(0, 0, 1, 0, 0, 16'd7);
    ticks_n(3);
    d0 = done_cnt;
    cycle(1, 1, 0, 0, 0, '0);
    cycle(1, 1, 0, 0, 0, '0);
    check_val("rst_run_count", {16'd0, count}, 32'd0);
    check_val("rst_run_busy", {31'd0, busy}, 32'd0);
    ticks_n(10);
    check_val("rst_no_done", done_cnt - d0, 32'd0);

    // Basic countdown with a sparse tick.
    $display("txn basic load=3");
    d0 = done_cnt;
    cycle(0, 0, 1, 0, 0, 16'd3);
    check_val("basic_load", {16'd0, count}, 32'd3);
    for (int i = 0; i < 12; i++) cycle(0, (i % 4) == 3, 0, 0, 0, '0);
    check_val("basic_count", {16'd0, count}, 32'd0);
    idle_n(3);
    check_val("basic_done", done_cnt - d0, 32'd1);

    // Zero load: immediate expiry, never busy.
    $display("txn zero load=0");
    d0 = done_cnt; b0 = busy_cnt;
    cycle(0, 0, 1, 0, 0, 16'd0);
    check_val("zero_done_now", {31'd0, done}, 32'd1);
    idle_n(2);
    check_val("zero_done", done_cnt - d0, 32'd1);
    check_val("zero_busy", busy_cnt - b0, 32'd0);

    // Maximum load with a tick every cycle.
    $display("txn max load=ffff");
    cycle(0, 0, 1, 0, 0, 16'hFFFF);
    nt = 0;
    while (!done && nt < 70000) begin
      cycle(0, 1, 0, 0, 0, '0);
      nt++;
    end
    check_val("max_ticks", nt, 32'd65535);

    // Pause: ticks on the pause edges are dropped.
    $display("txn pause load=5");
    d0 = done_cnt;
    cycle(0, 0, 1, 0, 0, 16'd5);
    ticks_n(2);
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 1, 0, '0);
    check_val("pause_hold", {16'd0, count}, 32'd3);
    check_val("pause_flag", {31'd0, paused}, 32'd1);
    cycle(0, 1, 0, 0, 0, '0);
    check_val("pause_release", {16'd0, count}, 32'd3);
    ticks_n(3);
    check_val("pause_done", done_cnt - d0, 32'd1);

    // Abort, then restart mid-run.
    $display("txn abort load=10");
    d0 = done_cnt;
    cycle(0, 0, 1, 0, 0, 16'd10);
    ticks_n(4);
    cycle(0, 0, 0, 0, 1, '0);
    check_val("abort_count", {16'd0, count}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    idle_n(3);
    check_val("abort_no_done", done_cnt - d0, 32'd0);
    $display("txn restart load=10 then 2");
    cycle(0, 0, 1, 0, 0, 16'd10);
    ticks_n(4);
    cycle(0, 0, 1, 0, 0, 16'd2);
    check_val("restart_count", {16'd0, count}, 32'd2);
    ticks_n(2);
    check_val("restart_done", done_cnt - d0, 32'd1);

    // Priority: abort beats start and tick; start beats tick in IDLE.
    $display("txn priority");
    d0 = done_cnt;
    cycle(0, 0, 1, 0, 0, 16'd10);
    cycle(0, 1, 1, 0, 1, 16'd5);
    check_val("prio_abort", {16'd0, count, busy}, 32'd0);
    cycle(0, 1, 1, 0, 0, 16'd1);
    check_val("prio_start", {15'd0, count, busy}, {15'd0, 16'd1, 1'b1});
    ticks_n(1);
    check_val("prio_done", done_cnt - d0, 32'd1);
    idle_n(2);

    check_val("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
